// File: rtl/demux7_1to2_buf.sv
// Buffered 1-to-2 demultiplexer: one valid/ready input stream is steered by in_sel into
// one of two single-entry registered output channels, each with a wrapping push counter.
module demux7_1to2_buf #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned CNTW  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [CNTW-1:0]  cnt0,
    output logic [CNTW-1:0]  cnt1
);

    typedef enum logic {StEmpty, StFull} state_e;

    state_e           state_q [2];
    state_e           state_d [2];
    logic [WIDTH-1:0] data_q  [2];
    logic [WIDTH-1:0] data_d  [2];
    logic [CNTW-1:0]  cnt_q   [2];
    logic [CNTW-1:0]  cnt_d   [2];

    logic [1:0] out_ready;
    logic [1:0] frees;
    logic [1:0] pop;
    logic [1:0] push;

    assign out_ready = {out1_ready, out0_ready};

    // A channel frees when empty or when its current word leaves this edge.
    always_comb begin
        frees = '0;
        pop   = '0;
        for (int i = 0; i < 2; i++) begin
            pop[i]   = (state_q[i] == StFull) && out_ready[i];
            frees[i] = (state_q[i] == StEmpty) || out_ready[i];
        end
    end

    // No bypass to the other channel: a blocked target stalls the whole input.
    assign in_ready = !reset && frees[in_sel];

    always_comb begin
        push = '0;
        for (int i = 0; i < 2; i++) begin
            push[i] = in_valid && in_ready && (in_sel == 1'(i));
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= StEmpty;
                data_q[i]  <= '0;
                cnt_q[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    // Next-state logic
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            data_d[i]  = data_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StEmpty: if (push[i]) state_d[i] = StFull;
                StFull:  if (pop[i] && !push[i]) state_d[i] = StEmpty;
                default: state_d[i] = StEmpty;
            endcase
            if (push[i]) begin
                data_d[i] = in_data;
                cnt_d[i]  = cnt_q[i] + 1'b1;
            end
        end
    end

    // Outputs
    always_comb begin
        out0_valid = (state_q[0] == StFull);
        out1_valid = (state_q[1] == StFull);
        out0_data  = data_q[0];
        out1_data  = data_q[1];
        cnt0       = cnt_q[0];
        cnt1       = cnt_q[1];
    end

endmodule
